// File: rtl/program_loader_if.sv
// Byte-stream input and program-RAM write port of the program loader.
// The master modport is the loader; the slave modport is the byte source plus RAM.
interface program_loader_if #(
  parameter int unsigned N      = 8,
  parameter int unsigned AddrSz = 6
);
  logic [7:0]        byte_data;
  logic              byte_valid;
  logic              byte_ready;
  logic              wr_en;
  logic [AddrSz-1:0] wr_addr;
  logic [N+15:0]     wr_data;

  modport master (
    input  byte_data,
    input  byte_valid,
    output byte_ready,
    output wr_en,
    output wr_addr,
    output wr_data
  );

  modport slave (
    output byte_data,
    output byte_valid,
    input  byte_ready,
    input  wr_en,
    input  wr_addr,
    input  wr_data
  );
endinterface

// File: rtl/program_loader.sv
// Fills the writable program store from a big-endian byte stream, one RAM write per
// assembled instruction word, holding the core in reset while a load is in progress.
module program_loader #(
  parameter int unsigned N             = 8,
  parameter int unsigned AddrSz        = 6,
  parameter int unsigned TimeoutCycles = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [AddrSz:0]  num_words,
  program_loader_if.master bus,
  output logic             busy,
  output logic             cpu_hold,
  output logic             done,
  output logic             error
);
  localparam int unsigned IW  = N + 16;
  localparam int unsigned BPW = (IW + 7) / 8;
  localparam int unsigned AW  = (BPW - 1) * 8;
  localparam int unsigned BIW = $clog2(BPW);
  localparam int unsigned TW  = $clog2(TimeoutCycles + 1);
  localparam int unsigned WW  = AddrSz + 1;

  localparam logic [BIW-1:0] LastByte = BIW'(BPW - 1);
  localparam logic [TW-1:0]  ToLast   = TW'(TimeoutCycles - 1);
  localparam logic [WW-1:0]  MaxWords = WW'(1) << AddrSz;

  typedef enum logic [1:0] {StIdle, StLoad, StDone, StErr} state_e;

  state_e          state_q;
  logic [WW-1:0]   word_cnt_q;
  logic [WW-1:0]   word_idx_q;
  logic [BIW-1:0]  byte_idx_q;
  logic [TW-1:0]   to_cnt_q;
  logic [AW-1:0]   acc_q;
  logic            ready_q;
  logic            wr_en_q;
  logic [AddrSz-1:0] wr_addr_q;
  logic [IW-1:0]   wr_data_q;
  logic            busy_q;
  logic            done_q;
  logic            error_q;

  logic            xfer;
  logic            last_byte;
  logic            last_word;
  logic [WW-1:0]   words_clamped;
  logic [BPW*8-1:0] assembled;

  // Earlier bytes of the word sit in acc_q; the current byte completes the picture.
  assign assembled     = {acc_q, bus.byte_data};
  assign xfer          = bus.byte_valid && ready_q;
  assign last_byte     = (byte_idx_q == LastByte);
  assign last_word     = (word_idx_q == (word_cnt_q - WW'(1)));
  assign words_clamped = (num_words > MaxWords) ? MaxWords : num_words;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      word_cnt_q <= '0;
      word_idx_q <= '0;
      byte_idx_q <= '0;
      to_cnt_q   <= '0;
      acc_q      <= '0;
      ready_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      case (state_q)
        StIdle, StDone, StErr: begin
          // done rises one cycle after entering DONE, i.e. after the final write cycle.
          if (state_q == StDone) done_q <= 1'b1;
          if (start) begin
            word_cnt_q <= words_clamped;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            to_cnt_q   <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            if (num_words == '0) begin
              state_q <= StDone;
            end else begin
              state_q <= StLoad;
              ready_q <= 1'b1;
              busy_q  <= 1'b1;
            end
          end
        end
        StLoad: begin
          if (xfer) begin
            to_cnt_q <= '0;
            if (last_byte) begin
              wr_en_q    <= 1'b1;
              wr_addr_q  <= word_idx_q[AddrSz-1:0];
              wr_data_q  <= assembled[IW-1:0];
              byte_idx_q <= '0;
              word_idx_q <= word_idx_q + WW'(1);
              if (last_word) begin
                state_q <= StDone;
                ready_q <= 1'b0;
                busy_q  <= 1'b0;
              end
            end else begin
              acc_q      <= assembled[AW-1:0];
              byte_idx_q <= byte_idx_q + BIW'(1);
            end
          end else if (to_cnt_q == ToLast) begin
            // Partial word is abandoned; acc_q is fully refilled by the next load.
            state_q <= StErr;
            error_q <= 1'b1;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
          end else begin
            to_cnt_q <= to_cnt_q + TW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.byte_ready = ready_q;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign busy           = busy_q;
  assign cpu_hold       = busy_q;
  assign done           = done_q;
  assign error          = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: byte-count reference model checked every
// cycle, plus literal checks on the words that reach the program RAM.
module tb_program_loader;
  localparam int unsigned N   = 8;
  localparam int unsigned AS  = 6;
  localparam int unsigned TO  = 1000;
  localparam int unsigned BPW = 3;

  typedef struct packed {
    logic [AS-1:0] addr;
    logic [23:0]   data;
  } wr_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [AS:0] num_words = '0;
  logic busy, cpu_hold, done, error;

  program_loader_if #(.N(N), .AddrSz(AS)) bus ();

  program_loader #(.N(N), .AddrSz(AS), .TimeoutCycles(TO)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .num_words(num_words),
    .bus      (bus.master),
    .busy     (busy),
    .cpu_hold (cpu_hold),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] stim[$];
  wr_t wlog[$];

  // Reference model state: phase 0 idle, 1 load, 2 done, 3 err.
  int m_phase = 0;
  int m_words = 0;
  int m_nbytes = 0;
  int m_idle = 0;
  logic [23:0] m_acc = '0;
  bit m_wr = 0;
  logic [AS-1:0] m_addr = '0;
  logic [23:0] m_data = '0;
  bit m_done = 0;
  bit m_err = 0;
  bit armed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_phase = 0; m_wr = 0; m_addr = '0; m_data = '0;
      m_done = 0; m_err = 0; m_nbytes = 0; m_idle = 0;
      armed = 1;
    end else begin
      m_wr = 0;
      if (m_phase == 1) begin
        if (bus.byte_valid) begin
          m_acc = {m_acc[15:0], bus.byte_data};
          m_nbytes++;
          m_idle = 0;
          if (m_nbytes % BPW == 0) begin
            m_wr = 1;
            m_addr = AS'(m_nbytes / BPW - 1);
            m_data = m_acc;
            if (m_nbytes / BPW == m_words) m_phase = 2;
          end
        end else begin
          m_idle++;
          if (m_idle == TO) begin m_phase = 3; m_err = 1; end
        end
      end else begin
        if (m_phase == 2) m_done = 1;
        if (start) begin
          m_words = (int'(num_words) > 64) ? 64 : int'(num_words);
          m_nbytes = 0; m_idle = 0; m_done = 0; m_err = 0;
          m_phase = (m_words == 0) ? 2 : 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("byte_ready", 32'(bus.byte_ready), 32'(m_phase == 1));
      chk("busy", 32'(busy), 32'(m_phase == 1));
      chk("cpu_hold", 32'(cpu_hold), 32'(m_phase == 1));
      chk("done", 32'(done), 32'(m_done));
      chk("error", 32'(error), 32'(m_err));
      chk("wr_en", 32'(bus.wr_en), 32'(m_wr));
      if (m_wr) begin
        chk("wr_addr", 32'(bus.wr_addr), 32'(m_addr));
        chk("wr_data", 32'(bus.wr_data), 32'(m_data));
      end
      if (bus.wr_en === 1'b1) wlog.push_back('{addr: bus.wr_addr, data: bus.wr_data});
    end
  end

  task automatic do_start(input int nw);
    @(negedge clk);
    start = 1'b1;
    num_words = (AS+1)'(nw);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Offers stim[first..first+cnt-1] in order; rnd inserts idle gaps.
  task automatic send(input int first, input int cnt, input bit rnd);
    int i = first;
    int guard = 0;
    bit rdy;
    while (i < first + cnt && guard < 5000) begin
      if (rnd && $urandom_range(0, 1) == 0) begin
        bus.byte_valid = 1'b0;
        bus.byte_data = 8'($urandom);
      end else begin
        bus.byte_valid = 1'b1;
        bus.byte_data = stim[i];
      end
      rdy = bus.byte_ready;
      @(posedge clk);
      if (bus.byte_valid && rdy) i++;
      guard++;
      @(negedge clk);
    end
    bus.byte_valid = 1'b0;
    chk("send_bound", 32'(i - first), 32'(cnt));
  endtask

  task automatic check_ram(input string name, input int n);
    chk({name, "_count"}, 32'(wlog.size()), 32'(n));
    for (int k = 0; k < n && k < wlog.size(); k++) begin
      chk({name, "_addr"}, 32'(wlog[k].addr), 32'(k));
      chk({name, "_data"}, 32'(wlog[k].data), {8'h0, stim[3*k], stim[3*k+1], stim[3*k+2]});
    end
  endtask

  initial begin
    bus.byte_valid = 1'b0;
    bus.byte_data = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_wr_addr", 32'(bus.wr_addr), 32'd0);
    chk("reset_wr_data", 32'(bus.wr_data), 32'd0);
    reset = 1'b0;

    // Two-word load with literal expectations.
    stim = '{8'h12, 8'h34, 8'h56, 8'hAB, 8'hCD, 8'hEF};
    wlog.delete();
    do_start(2);
    send(0, 6, 0);
    @(negedge clk);
    chk("t1_count", 32'(wlog.size()), 32'd2);
    if (wlog.size() >= 2) begin
      chk("t1_word0", 32'(wlog[0].data), 32'h123456);
      chk("t1_word1", 32'(wlog[1].data), 32'hABCDEF);
      chk("t1_addr1", 32'(wlog[1].addr), 32'd1);
    end
    chk("t1_done", 32'(done), 32'd1);

    // Full-capacity load with byte_valid held high.
    stim.delete();
    for (int i = 0; i < 192; i++) stim.push_back(8'(i * 7 + 3));
    wlog.delete();
    do_start(64);
    send(0, 192, 0);
    repeat (2) @(negedge clk);
    check_ram("t2", 64);
    chk("t2_done", 32'(done), 32'd1);
    chk("t2_error", 32'(error), 32'd0);

    // Oversized count clamps to capacity.
    wlog.delete();
    do_start(127);
    send(0, 192, 0);
    repeat (2) @(negedge clk);
    check_ram("clamp", 64);
    chk("clamp_done", 32'(done), 32'd1);

    // Zero-word load, then start ignored during a load.
    wlog.delete();
    do_start(0);
    repeat (3) @(negedge clk);
    chk("t3_done", 32'(done), 32'd1);
    chk("t3_nowrite", 32'(wlog.size()), 32'd0);
    stim = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    do_start(2);
    send(0, 3, 0);
    do_start(5);
    send(3, 3, 0);
    repeat (2) @(negedge clk);
    check_ram("t3", 2);
    chk("t3_done2", 32'(done), 32'd1);

    // Timeout after a partial second word.
    stim = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    wlog.delete();
    do_start(2);
    send(0, 4, 0);
    repeat (TO - 2) @(negedge clk);
    chk("t4_no_early_error", 32'(error), 32'd0);
    repeat (4) @(negedge clk);
    chk("t4_error", 32'(error), 32'd1);
    chk("t4_busy", 32'(busy), 32'd0);
    check_ram("t4", 1);

    // Reset mid-load, then reload from address 0.
    stim = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    wlog.delete();
    do_start(2);
    send(0, 5, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("t5_wr_en", 32'(bus.wr_en), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_ready", 32'(bus.byte_ready), 32'd0);
    reset = 1'b0;
    chk("t5_one_write", 32'(wlog.size()), 32'd1);
    stim = '{8'h9A, 8'hBC, 8'hDE};
    wlog.delete();
    do_start(1);
    send(0, 3, 0);
    repeat (2) @(negedge clk);
    check_ram("t5", 1);

    // Randomly gapped five-word load.
    stim.delete();
    for (int i = 0; i < 15; i++) stim.push_back(8'($urandom));
    wlog.delete();
    do_start(5);
    send(0, 15, 1);
    repeat (3) @(negedge clk);
    check_ram("t6", 5);
    chk("t6_done", 32'(done), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
